// File: rtl/armleocpu_axi_sched_pkg.sv
// Shared definitions for the AXI transaction schedulers: FSM encoding and
// index-width derivation.
package armleocpu_axi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } sched_state_t;

    // A single host still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/armleocpu_rr_picker.sv
// Combinational round-robin picker: first set req bit strictly after last_idx,
// wrapping around. Shared by the read and write schedulers.
module armleocpu_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    int  cand;
    logic found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        found    = 1'b0;
        cand     = 0;
        // Offsets 1..N visit every host once, ending with last_idx itself.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_idx) + k) % N;
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
        any = found;
    end

endmodule

// File: rtl/armleocpu_axi_write_sched.sv
// Round-robin owner of the shared AXI4 write path: grants one host for a full
// AW / W-burst / B transaction, then rotates priority.
module armleocpu_axi_write_sched
    import armleocpu_axi_sched_pkg::*;
#(
    parameter  int OPT_NUMBER_OF_HOSTS = 2,
    localparam int IDX_W               = idx_w(OPT_NUMBER_OF_HOSTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [OPT_NUMBER_OF_HOSTS-1:0] req,
    input  logic                           aw_fire,
    input  logic                           w_last_fire,
    input  logic                           b_fire,
    output logic [OPT_NUMBER_OF_HOSTS-1:0] grant,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           grant_valid,
    output logic                           protocol_error
);

    sched_state_t                   state;
    logic [IDX_W-1:0]               last_idx;
    logic                           aw_done;
    logic                           w_done;
    logic [OPT_NUMBER_OF_HOSTS-1:0] pick;
    logic [IDX_W-1:0]               pick_idx;
    logic                           pick_any;

    armleocpu_rr_picker #(
        .N     (OPT_NUMBER_OF_HOSTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req      (req),
        .last_idx (last_idx),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= '0;
            grant_idx      <= '0;
            grant_valid    <= 1'b0;
            protocol_error <= 1'b0;
            // Pointer at the last host so host 0 wins the first arbitration.
            last_idx       <= IDX_W'(OPT_NUMBER_OF_HOSTS - 1);
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_fire || w_last_fire || b_fire)
                        protocol_error <= 1'b1;
                    if (pick_any) begin
                        grant       <= pick;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Duplicate or early events flag an error and are dropped.
                    if (b_fire || (aw_fire && aw_done) || (w_last_fire && w_done))
                        protocol_error <= 1'b1;
                    if (aw_fire)
                        aw_done <= 1'b1;
                    if (w_last_fire)
                        w_done <= 1'b1;
                    if ((aw_done || aw_fire) && (w_done || w_last_fire))
                        state <= RESP;
                end
                RESP: begin
                    if (aw_fire || w_last_fire)
                        protocol_error <= 1'b1;
                    if (b_fire) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        last_idx    <= grant_idx;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_axi_write_sched.sv
// Bench for armleocpu_axi_write_sched (4 hosts): transaction-level model checked
// every cycle, plus literal expectations along directed scenarios.
module tb_armleocpu_axi_write_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         aw_fire = 1'b0;
    logic         w_last_fire = 1'b0;
    logic         b_fire = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         grant_valid;
    logic         protocol_error;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    armleocpu_axi_write_sched #(.OPT_NUMBER_OF_HOSTS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .aw_fire        (aw_fire),
        .w_last_fire    (w_last_fire),
        .b_fire         (b_fire),
        .grant          (grant),
        .grant_idx      (grant_idx),
        .grant_valid    (grant_valid),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the path, which events it has seen,
    // who was served last, and whether any rule was broken.
    int m_owner = -1;
    bit m_aw_seen = 1'b0;
    bit m_w_seen = 1'b0;
    int m_ptr = N - 1;
    bit m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_aw_seen = 0; m_w_seen = 0; m_ptr = N - 1; m_err = 0;
        end else if (m_owner < 0) begin
            if (aw_fire || w_last_fire || b_fire) m_err = 1;
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_aw_seen = 0;
                    m_w_seen = 0;
                end
            end
        end else if (!(m_aw_seen && m_w_seen)) begin
            if (b_fire) m_err = 1;
            if (aw_fire) begin
                if (m_aw_seen) m_err = 1;
                m_aw_seen = 1;
            end
            if (w_last_fire) begin
                if (m_w_seen) m_err = 1;
                m_w_seen = 1;
            end
        end else begin
            if (aw_fire || w_last_fire) m_err = 1;
            if (b_fire) begin
                m_ptr = m_owner;
                m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("m_grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("m_valid", grant_valid, (m_owner >= 0) ? 1 : 0);
            if (m_owner >= 0) check("m_idx", grant_idx, m_owner);
            check("m_err", protocol_error, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_aw();
        aw_fire = 1; cyc(); aw_fire = 0;
    endtask
    task automatic pulse_w();
        w_last_fire = 1; cyc(); w_last_fire = 0;
    endtask
    task automatic pulse_b();
        b_fire = 1; cyc(); b_fire = 0;
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 6 && !grant_valid; i++) cyc();
        if (!grant_valid) check("grant_timeout", grant_valid, 1);
    endtask

    task automatic reset_pulse();
        #2 rst = 1;
        #2 rst = 0;
    endtask

    initial begin
        repeat (2) cyc();
        check("rst_grant", grant, 0);
        check("rst_valid", grant_valid, 0);
        check("rst_err", protocol_error, 0);
        rst = 0;

        // Two requesters: host 0 first, then one idle cycle, then host 1.
        req = 4'b0011;
        cyc();
        check("t1_grant0", grant, 4'b0001);
        check("t1_idx0", grant_idx, 0);
        pulse_aw(); pulse_w(); pulse_b();
        check("t1_bubble", grant_valid, 0);
        cyc();
        check("t1_grant1", grant, 4'b0010);
        pulse_aw(); pulse_w(); pulse_b();
        req = '0;
        cyc();

        // Full rotation over four hosts, twice.
        reset_pulse();
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            wait_grant();
            check("rr_idx", grant_idx, t % 4);
            pulse_aw(); pulse_w(); pulse_b();
        end
        req = '0;
        cyc();

        // W-last ahead of AW with gaps, then both events in one cycle.
        req = 4'b0100;
        wait_grant();
        cyc();
        pulse_w();
        cyc();
        pulse_aw();
        check("wfirst_hold", grant, 4'b0100);
        pulse_b();
        check("wfirst_release", grant_valid, 0);
        check("wfirst_noerr", protocol_error, 0);
        wait_grant();
        aw_fire = 1; w_last_fire = 1; cyc(); aw_fire = 0; w_last_fire = 0;
        pulse_b();
        check("same_release", grant_valid, 0);
        check("same_noerr", protocol_error, 0);
        req = '0;
        cyc();

        // Owner drops req mid-burst while host 1 asks; grant holds to b_fire.
        reset_pulse();
        req = 4'b0001;
        cyc();
        check("drop_grant0", grant, 4'b0001);
        req = 4'b0010;
        pulse_aw(); pulse_w();
        check("drop_hold", grant, 4'b0001);
        pulse_b();
        cyc();
        check("drop_grant1", grant, 4'b0010);

        // b_fire too early: sticky error, grant and progress unaffected.
        pulse_b();
        check("early_b_err", protocol_error, 1);
        check("early_b_grant", grant, 4'b0010);
        req = '0;
        pulse_aw(); pulse_w(); pulse_b();
        check("early_b_release", grant_valid, 0);
        check("err_sticky", protocol_error, 1);

        // Reset while in RESP takes effect between clock edges.
        req = 4'b0001;
        wait_grant();
        aw_fire = 1; w_last_fire = 1; cyc(); aw_fire = 0; w_last_fire = 0;
        req = '0;
        #2 rst = 1;
        #1;
        check("async_grant", grant, 0);
        check("async_valid", grant_valid, 0);
        check("async_err", protocol_error, 0);
        cyc();
        rst = 0;
        req = 4'b0010;
        cyc();
        check("post_rst_grant", grant, 4'b0010);
        check("post_rst_idx", grant_idx, 1);
        pulse_aw(); pulse_w(); pulse_b();
        req = '0;
        cyc();

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/armleocpu_axi_write_sched.md
# armleocpu_axi_write_sched

Transaction-level round-robin scheduler that shares one downstream AXI4 write path (AW, W, B) among OPT_NUMBER_OF_HOSTS requesting hosts. It issues a registered one-hot grant, holds it for one full write transaction (address, data burst up to WLAST, response), then rotates priority. It sits beside the N-to-1 AXI arbiter datapath and drives that arbiter's mux selects; it never touches payload signals.

## Interface
- OPT_NUMBER_OF_HOSTS, 2, number of hosts, 1 or more.
- IDX_W, derived: 1 when OPT_NUMBER_OF_HOSTS==1, else $clog2(OPT_NUMBER_OF_HOSTS); not user-overridable.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  OPT_NUMBER_OF_HOSTS  per-host write request (host AWVALID or W-first WVALID).
- aw_fire  in  1  downstream AWVALID&&AWREADY of the granted host.
- w_last_fire  in  1  downstream WVALID&&WREADY&&WLAST of the granted host.
- b_fire  in  1  downstream BVALID&&BREADY to the granted host.
- grant  out  OPT_NUMBER_OF_HOSTS  one-hot grant, all zero when idle.
- grant_idx  out  IDX_W  binary index of grant; valid only when grant_valid.
- grant_valid  out  1  a transaction owns the path.
- protocol_error  out  1  sticky; set on out-of-order fire events.

## Operation
- States: IDLE, ACTIVE, RESP. Reset: state=IDLE, grant=0, grant_idx=0, grant_valid=0, protocol_error=0, last_idx=OPT_NUMBER_OF_HOSTS-1 (host 0 wins first).
- IDLE: if any req bit set, pick first set bit searching from last_idx+1 upward with wrap; register grant/grant_idx, grant_valid=1, clear aw_done/w_done, go ACTIVE. No req: stay.
- ACTIVE: aw_fire sets aw_done; w_last_fire sets w_done; either order, same cycle allowed. When both done (including events this cycle) go RESP.
- RESP: on b_fire: grant=0, grant_valid=0, last_idx=grant_idx, go IDLE.
- Grant is held regardless of req changes of the owner; req of non-owners ignored until IDLE.
- protocol_error set when: b_fire outside RESP; aw_fire while aw_done already set; w_last_fire while w_done already set; any fire in IDLE. Offending event otherwise ignored (no state change). Cleared only by rst.
- OPT_NUMBER_OF_HOSTS==1: search degenerates, grant_idx always 0.

## Timing
- Arbitration latency: req high in cycle T while IDLE -> grant_valid high in T+1.
- Release: b_fire in cycle T -> grant_valid low in T+1; new grant earliest T+2 (one mandatory idle cycle, bubble accepted).
- aw_fire and w_last_fire in same cycle T -> RESP in T+1; b_fire accepted in T+1.
- Minimum transaction occupancy: 2 grant cycles (ACTIVE then RESP).
- All outputs registered; no combinational path from req or fire inputs to outputs.
- rst asserted mid-transaction: outputs go to reset values immediately (asynchronous), priority pointer reset; downstream cleanup is the datapath's responsibility.

## Structure
- Shared package armleocpu_axi_sched_pkg: state encoding localparams (IDLE=2'd0, ACTIVE=2'd1, RESP=2'd2), IDX_W derivation function.
- Sub-module armleocpu_rr_picker: combinational, inputs req and last_idx, outputs one-hot pick, pick_idx, any; reused later by the read scheduler.

## Test plan
- Reset then req=2'b11 -> cycle+1 grant=2'b01, grant_idx=0; after aw_fire, w_last_fire, b_fire -> one idle cycle, then grant=2'b10.
- N=4, req=4'b1111 held, 8 full transactions -> grant order 0,1,2,3,0,1,2,3, each exactly once per round.
- W before AW: w_last_fire at cycle 3, aw_fire at cycle 5 -> RESP entered cycle 6; both same cycle -> RESP next cycle.
- Owner drops req mid-burst, req of host 1 rises -> grant unchanged until b_fire, then host 1 granted.
- b_fire during ACTIVE -> protocol_error=1 next cycle, state stays ACTIVE, grant unchanged; stays 1 until rst.
- rst pulsed during RESP -> grant=0, grant_valid=0 without clock edge; next req=2'b10 -> grant host 1, priority pointer at reset value.
